// File: rtl/rv_pkg.sv
// Shared RISC-V SoC constants used by the bus fabric and its peripherals.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  // Base address of the UART register block
  localparam logic [31:0] ADDRESS_UART = 32'h1000_0000;

endpackage

// File: rtl/rv_uart_arbiter.sv
// Two-master arbiter in front of the shared rv_uart_driver.
// Grants one master at a time, alternating on contention, latches the
// winner's request fields for the whole transaction, and bounds every
// grant with a cycle counter that forces an error completion on expiry.
module rv_uart_arbiter #(
  parameter int unsigned     XLEN           = rv_pkg::XLEN,
  parameter int unsigned     TIMEOUT_CYCLES = 4096,
  parameter logic [XLEN-1:0] ERR_RDATA      = XLEN'(32'hBAD0_BAD0)
) (
  input  logic              clk_i,
  input  logic              arstn_i,

  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [XLEN/8-1:0] m0_be_i,
  input  logic [XLEN-1:0]   m0_addr_i,
  input  logic [XLEN-1:0]   m0_wdata_i,
  output logic              m0_rvalid_o,
  output logic [XLEN-1:0]   m0_rdata_o,

  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [XLEN/8-1:0] m1_be_i,
  input  logic [XLEN-1:0]   m1_addr_i,
  input  logic [XLEN-1:0]   m1_wdata_i,
  output logic              m1_rvalid_o,
  output logic [XLEN-1:0]   m1_rdata_o,

  output logic              s_req_o,
  output logic              s_we_o,
  output logic [XLEN/8-1:0] s_be_o,
  output logic [XLEN-1:0]   s_addr_o,
  output logic [XLEN-1:0]   s_wdata_o,
  input  logic              s_rvalid_i,
  input  logic [XLEN-1:0]   s_rdata_i,

  output logic [1:0]        grant_o,
  output logic              timeout_o
);

  localparam int unsigned    BW       = XLEN / 8;
  localparam int unsigned    CW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;  // 0: m0 won last, 1: m1 won last
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic              we_q, we_d;
  logic [BW-1:0]     be_q, be_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;

  logic              granted;
  logic              timeout_hit;
  logic              done;
  logic              pick_m1;
  logic [XLEN-1:0]   resp_data;

  // Grant status: a real response always beats the timeout on the same cycle
  always_comb begin
    granted     = (state_q == GRANT0) || (state_q == GRANT1);
    timeout_hit = granted && (cnt_q == CNT_LAST) && !s_rvalid_i;
    done        = granted && (s_rvalid_i || timeout_hit);
    resp_data   = s_rvalid_i ? s_rdata_i : ERR_RDATA;
  end

  // Next-state, arbitration and request-field capture
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    timeout_d    = timeout_q;
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    // m1 wins when it is alone, or when both ask and m0 won last time
    pick_m1      = m1_req_i && (!m0_req_i || !last_grant_q);

    unique case (state_q)
      IDLE: begin
        if (m0_req_i || m1_req_i) begin
          state_d      = pick_m1 ? GRANT1 : GRANT0;
          last_grant_d = pick_m1;
          cnt_d        = '0;
          we_d         = pick_m1 ? m1_we_i    : m0_we_i;
          be_d         = pick_m1 ? m1_be_i    : m0_be_i;
          addr_d       = pick_m1 ? m1_addr_i  : m0_addr_i;
          wdata_d      = pick_m1 ? m1_wdata_i : m0_wdata_i;
        end
      end
      GRANT0, GRANT1: begin
        cnt_d = cnt_q + CW'(1);
        if (done) begin
          state_d = IDLE;
        end
        if (timeout_hit) begin
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and latched request registers
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
      we_q         <= 1'b0;
      be_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
      we_q         <= we_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Output decode: driver side from latched fields, completions routed to the owner only
  always_comb begin
    s_req_o     = granted && !s_rvalid_i && !timeout_hit;
    s_we_o      = we_q;
    s_be_o      = be_q;
    s_addr_o    = addr_q;
    s_wdata_o   = wdata_q;
    m0_rvalid_o = done && (state_q == GRANT0);
    m1_rvalid_o = done && (state_q == GRANT1);
    m0_rdata_o  = m0_rvalid_o ? resp_data : '0;
    m1_rdata_o  = m1_rvalid_o ? resp_data : '0;
    grant_o     = {state_q == GRANT1, state_q == GRANT0};
    timeout_o   = timeout_q;
  end

endmodule

// File: tb/tb_rv_uart_arbiter.sv
// Bench for rv_uart_arbiter: directed scenarios plus a randomized phase,
// every cycle checked against a transaction-level reference model.
module tb_rv_uart_arbiter;

  localparam int unsigned TMO = 8;
  localparam logic [31:0] ERR = 32'hBAD0_BAD0;

  logic        clk_i = 1'b0;
  logic        arstn_i = 1'b1;
  logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [3:0]  m0_be_i, m1_be_i;
  logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
  logic        m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        s_req_o, s_we_o, s_rvalid_i;
  logic [3:0]  s_be_o;
  logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
  logic [1:0]  grant_o;
  logic        timeout_o;

  always #5 clk_i = ~clk_i;

  rv_uart_arbiter #(
    .XLEN(32),
    .TIMEOUT_CYCLES(TMO),
    .ERR_RDATA(ERR)
  ) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
    .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
    .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
    .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  // Reference model: owner of the open transaction (-1 none), its age in
  // cycles, the previous winner, sticky timeout and the captured request.
  int          own, prev, age, plan;
  bit          tflag;
  logic        mwe;
  logic [3:0]  mbe;
  logic [31:0] maddr, mwdata;

  int          tests = 0, fails = 0;
  int          sreq_hi, pulses0, pulses1;
  logic [1:0]  glog[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    own = -1; prev = 1; age = 0; tflag = 0;
    mwe = 0; mbe = '0; maddr = '0; mwdata = '0;
  endtask

  task automatic model_edge();
    int w;
    if (own < 0) begin
      if (m0_req_i || m1_req_i) begin
        if (m0_req_i && m1_req_i) w = 1 - prev;
        else                      w = m1_req_i ? 1 : 0;
        own = w; prev = w; age = 0;
        if (w == 0) {mwe, mbe, maddr, mwdata} = {m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i};
        else        {mwe, mbe, maddr, mwdata} = {m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i};
      end
    end else begin
      if (s_rvalid_i || age == TMO - 1) begin
        if (!s_rvalid_i) tflag = 1;
        own = -1;
      end
      age++;
    end
  endtask

  task automatic check_outputs();
    logic        expire, resp;
    logic [31:0] rd;
    expire = (own >= 0) && (age == TMO - 1) && !s_rvalid_i;
    resp   = (own >= 0) && (s_rvalid_i || expire);
    rd     = s_rvalid_i ? s_rdata_i : ERR;
    chk("grant", grant_o, own == 0 ? 2'b01 : own == 1 ? 2'b10 : 2'b00);
    chk("s_req", s_req_o, (own >= 0) && !s_rvalid_i && !expire);
    chk("s_fields", {s_we_o, s_be_o, s_addr_o, s_wdata_o}, {mwe, mbe, maddr, mwdata});
    chk("m0_resp", {m0_rvalid_o, m0_rdata_o}, (resp && own == 0) ? {1'b1, rd} : 33'd0);
    chk("m1_resp", {m1_rvalid_o, m1_rdata_o}, (resp && own == 1) ? {1'b1, rd} : 33'd0);
    chk("timeout", timeout_o, tflag);
    if (s_req_o === 1'b1) sreq_hi++;
    if (m0_rvalid_o === 1'b1) pulses0++;
    if (m1_rvalid_o === 1'b1) pulses1++;
    if (glog.size() == 0 || glog[$] !== grant_o) glog.push_back(grant_o);
  endtask

  // Called at posedge+1 with inputs already applied; returns at the next posedge+1
  task automatic tick();
    #2 check_outputs();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic clr_stats();
    sreq_hi = 0; pulses0 = 0; pulses1 = 0;
    glog.delete();
  endtask

  task automatic idle_inputs();
    m0_req_i = 0; m0_we_i = 0; m0_be_i = '0; m0_addr_i = '0; m0_wdata_i = '0;
    m1_req_i = 0; m1_we_i = 0; m1_be_i = '0; m1_addr_i = '0; m1_wdata_i = '0;
    s_rvalid_i = 0; s_rdata_i = '0;
  endtask

  task automatic hard_reset();
    arstn_i = 1'b0;
    model_reset();
    #1 check_outputs();
    repeat (2) @(posedge clk_i);
    #1 arstn_i = 1'b1;
  endtask

  // Grant-change history packed two bits per entry, with its length
  function automatic logic [47:0] glog_word();
    logic [15:0] p;
    p = '0;
    foreach (glog[i]) if (i < 8) p = {p[13:0], glog[i]};
    return {32'(glog.size()), p};
  endfunction

  function automatic logic [47:0] winners_word();
    logic [15:0] p;
    int          n;
    p = '0; n = 0;
    foreach (glog[i]) if (glog[i] != 2'b00 && n < 8) begin p = {p[13:0], glog[i]}; n++; end
    return {32'(n), p};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    model_reset();
    plan = 0;
    #1 hard_reset();

    // Single write from m0, driver answers 3 cycles after s_req rises
    clr_stats();
    m0_req_i = 1; m0_we_i = 1; m0_be_i = 4'hF;
    m0_addr_i = rv_pkg::ADDRESS_UART; m0_wdata_i = 32'h41;
    tick();
    m0_req_i = 0;
    tick();
    chk("s_wdata_41", s_wdata_o, 32'h41);
    tick(); tick();
    s_rvalid_i = 1; s_rdata_i = $urandom;
    tick();
    s_rvalid_i = 0;
    tick();
    chk("wr_sreq_cycles", sreq_hi, 3);
    chk("wr_m0_pulses", pulses0, 1);
    chk("wr_m1_pulses", pulses1, 0);
    chk("wr_grant_seq", glog_word(), {32'd3, 16'b0000000000_00_01_00});

    // Contention straight after reset: m0 first, idle gap, then m1
    hard_reset();
    clr_stats();
    m0_req_i = 1; m0_addr_i = 32'hA000_0000;
    m1_req_i = 1; m1_addr_i = 32'hB000_0000; m1_wdata_i = 32'h1111_2222;
    tick();
    m0_req_i = 0; s_rvalid_i = 1; s_rdata_i = 32'hCAFE_0001;
    tick();
    s_rvalid_i = 0;
    tick();
    m1_req_i = 0; s_rvalid_i = 1; s_rdata_i = 32'hCAFE_0002;
    tick();
    s_rvalid_i = 0;
    tick();
    chk("cont_grant_seq", glog_word(), {32'd5, 16'b000000_00_01_00_10_00});
    chk("cont_pulses", {pulses0[7:0], pulses1[7:0]}, 16'h0101);

    // Fairness: both hold req for six transactions with random driver latency
    clr_stats();
    m0_req_i = 1; m1_req_i = 1;
    for (int i = 0; i < 100 && (pulses0 + pulses1) < 6; i++) begin
      m0_addr_i = $urandom; m1_addr_i = $urandom;
      m0_wdata_i = $urandom; m1_wdata_i = $urandom;
      if (own >= 0) s_rvalid_i = (age == plan);
      else begin plan = $urandom_range(0, 3); s_rvalid_i = 0; end
      s_rdata_i = $urandom;
      tick();
    end
    idle_inputs();
    tick();
    chk("fair_order", winners_word(), {32'd6, 16'b0000_01_10_01_10_01_10});
    chk("fair_counts", {pulses0[7:0], pulses1[7:0]}, 16'h0303);

    // Response arriving on the last allowed cycle beats the timeout
    m0_req_i = 1; m0_addr_i = 32'h0000_0100;
    tick();
    m0_req_i = 0;
    repeat (TMO - 1) tick();
    s_rvalid_i = 1; s_rdata_i = 32'h0000_1234;
    tick();
    s_rvalid_i = 0;
    chk("race_timeout_flag", timeout_o, 1'b0);
    tick();

    // Timeout on m1: silent driver, error completion on the 8th grant cycle
    clr_stats();
    m1_req_i = 1; m1_addr_i = $urandom; m1_wdata_i = $urandom; m1_be_i = 4'h3;
    tick();
    m1_req_i = 0;
    repeat (TMO) tick();
    chk("tmo_flag_set", timeout_o, 1'b1);
    chk("tmo_m1_pulses", pulses1, 1);
    s_rvalid_i = 1; s_rdata_i = 32'h0000_0077;
    tick();
    s_rvalid_i = 0;
    repeat (3) tick();
    chk("tmo_late_ignored", {pulses0[7:0], pulses1[7:0]}, 16'h0001);
    chk("tmo_flag_sticky", timeout_o, 1'b1);

    // m0 drops req after the grant; completion still delivered from latched request
    clr_stats();
    m0_req_i = 1; m0_we_i = 0; m0_be_i = 4'hF; m0_addr_i = rv_pkg::ADDRESS_UART + 32'd4;
    tick();
    tick();
    m0_req_i = 0; m0_addr_i = 32'hDEAD_BEEF;
    tick(); tick();
    chk("drop_addr", s_addr_o, rv_pkg::ADDRESS_UART + 32'd4);
    s_rvalid_i = 1; s_rdata_i = 32'h55;
    #1 chk("drop_rdata", {m0_rvalid_o, m0_rdata_o}, {1'b1, 32'h55});
    tick();
    s_rvalid_i = 0;
    tick();
    chk("drop_pulses", pulses0, 1);

    // Reset in the middle of a grant
    clr_stats();
    m1_req_i = 1; m1_addr_i = 32'h2000_0000;
    tick();
    m1_req_i = 0;
    tick();
    #2 arstn_i = 1'b0;
    model_reset();
    #1 check_outputs();
    chk("rst_all_zero", {s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o, grant_o, timeout_o,
                          m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o}, '0);
    repeat (2) @(posedge clk_i);
    #1 arstn_i = 1'b1;
    s_rvalid_i = 1; s_rdata_i = 32'h0000_0099;
    tick(); tick();
    s_rvalid_i = 0;
    tick();
    chk("rst_no_pulse", pulses0 + pulses1, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      m0_req_i = ($urandom_range(0, 2) != 0); m1_req_i = ($urandom_range(0, 2) != 0);
      m0_we_i = $urandom_range(0, 1); m1_we_i = $urandom_range(0, 1);
      m0_be_i = 4'($urandom); m1_be_i = 4'($urandom);
      m0_addr_i = $urandom; m1_addr_i = $urandom;
      m0_wdata_i = $urandom; m1_wdata_i = $urandom;
      if (own >= 0) s_rvalid_i = (age == plan);
      else begin plan = $urandom_range(0, 9); s_rvalid_i = ($urandom_range(0, 3) == 0); end
      s_rdata_i = $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rv_uart_arbiter.md
RV_UART_ARBITER -- requirements
Module: rv_uart_arbiter

Interface
- REQ-001: The module SHALL have exactly one clock, clk_i, and one asynchronous active-low reset, arstn_i. All state SHALL be clocked on the rising edge of clk_i and cleared while arstn_i=0.
- REQ-002: Parameters, one per line:
  - XLEN, default rv_pkg::XLEN (32): data and address width.
  - TIMEOUT_CYCLES, default 4096: maximum grant length in cycles; legal range is 2 or more.
  - ERR_RDATA, default 32'hBAD0_BAD0: read data returned on a timeout.
- REQ-003: Ports, one per line (name, direction, width, meaning):
  - clk_i, in, 1: clock.
  - arstn_i, in, 1: async reset, active-low.
  - m0_req_i / m1_req_i, in, 1: requester N access request.
  - m0_we_i / m1_we_i, in, 1: write enable.
  - m0_be_i / m1_be_i, in, XLEN/8: byte enables.
  - m0_addr_i / m1_addr_i, in, XLEN: address.
  - m0_wdata_i / m1_wdata_i, in, XLEN: write data.
  - m0_rvalid_o / m1_rvalid_o, out, 1: one-cycle completion pulse.
  - m0_rdata_o / m1_rdata_o, out, XLEN: read data, valid while rvalid=1.
  - s_req_o, out, 1: request to the shared rv_uart_driver.
  - s_we_o, out, 1: write enable to the driver.
  - s_be_o, out, XLEN/8: byte enables to the driver.
  - s_addr_o, out, XLEN: address to the driver.
  - s_wdata_o, out, XLEN: write data to the driver.
  - s_rvalid_i, in, 1: driver completion.
  - s_rdata_i, in, XLEN: driver read data.
  - grant_o, out, 2: one-hot current owner; 00 when idle.
  - timeout_o, out, 1: sticky timeout flag.

Function
- REQ-004: FSM states SHALL be IDLE, GRANT0 and GRANT1.
- REQ-005: In IDLE, a single requesting master SHALL be granted. The next state SHALL be GRANTn.
- REQ-006: On simultaneous requests in IDLE, the master not granted last SHALL win. A last_grant register SHALL record the previous winner.
- REQ-007: On the grant edge, the winner's we, be, addr and wdata SHALL be latched. s_we_o, s_be_o, s_addr_o and s_wdata_o SHALL drive the latched copies only.
- REQ-008: s_req_o SHALL equal (state is GRANTn) AND NOT s_rvalid_i AND NOT timeout_hit.
  - First s_req_o assertion is 1 cycle after the request is sampled in IDLE.
- REQ-009: When s_rvalid_i=1 in GRANTn:
  - mn_rvalid_o SHALL be 1 in the same cycle, combinationally.
  - mn_rdata_o SHALL equal s_rdata_i.
  - The next state SHALL be IDLE.
- REQ-010: The non-granted master SHALL always see rvalid=0 and rdata=0.
- REQ-011: s_rvalid_i received in IDLE SHALL be ignored; a late response is dropped.
- REQ-012: At least one IDLE cycle SHALL separate consecutive grants.
- REQ-013: Deassertion of mn_req_i after the grant SHALL NOT abort the transaction. Completion SHALL still be pulsed to master n.
- REQ-014: Cycle counter behaviour:
  - The counter SHALL have width $clog2(TIMEOUT_CYCLES).
  - It SHALL clear on grant and increment in each GRANT cycle.
  - timeout_hit SHALL be (counter == TIMEOUT_CYCLES-1) AND NOT s_rvalid_i.
- REQ-015: When timeout_hit=1:
  - mn_rvalid_o SHALL be 1 and mn_rdata_o SHALL equal ERR_RDATA.
  - s_req_o SHALL be 0.
  - timeout_o SHALL set, and the next state SHALL be IDLE.
- REQ-016: If s_rvalid_i=1 on the timeout cycle, the real response SHALL win and timeout_o SHALL be unchanged.
- REQ-017: grant_o SHALL be 01 in GRANT0, 10 in GRANT1 and 00 in IDLE. It SHALL be driven from state.

Reset
- REQ-018: Reset SHALL set the following values, including in the middle of a transaction:
  - state=IDLE and last_grant=m1, so m0 wins the first contention.
  - counter=0 and timeout_o=0.
  - Latched fields = 0.
- REQ-019: During reset, all outputs SHALL be 0. The in-flight transaction SHALL be discarded with no rvalid pulse.

Verification
- REQ-020: Single write. m0 requests with we=1, addr=ADDRESS_UART and wdata=0x41, and the driver gives s_rvalid_i 3 cycles after s_req_o rises. Required response:
  - s_req_o is high for 3 cycles.
  - s_wdata_o=0x41.
  - m0_rvalid_o pulses once; m1_rvalid_o stays 0.
  - grant_o=01 then 00.
- REQ-021: Contention after reset. m0 and m1 request in the same cycle. Required response:
  - m0 is served first, then an IDLE cycle, then m1.
  - grant_o sequence is 01, 00, 10.
- REQ-022: Fairness. Both masters hold req continuously for 6 transactions. Required response:
  - Grants alternate m0, m1, m0, m1, m0, m1.
  - Neither master is starved.
- REQ-023: Timeout. TIMEOUT_CYCLES=8 and the driver never responds. Required response:
  - On the 8th GRANT cycle, m1_rvalid_o=1 with m1_rdata_o=0xBAD0BAD0.
  - timeout_o=1 and stays 1.
  - A late s_rvalid_i in IDLE is ignored.
- REQ-024: Request drop and reset. m0 drops req 1 cycle after grant and the driver returns rdata=0x55 later. Required response:
  - m0_rvalid_o pulses with 0x55, using the latched address.
  - A separate run asserts arstn_i low mid-grant: all outputs go to 0 at once, and no rvalid pulse occurs after reset release.
